// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with per-register pending (scoreboard) bits.
// Optional write-through forwarding to the read ports is enabled by defining REGFILE_MP_BYPASS_EN.
module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0]          ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0]          data_writeReg,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] ctrl_readReg,
    output logic [NUM_READ*DATA_WIDTH-1:0] data_readReg,
    output logic [NUM_READ-1:0]            read_busy,
    input  logic                           ctrl_reserve,
    input  logic [ADDR_WIDTH-1:0]          ctrl_reserveReg,
    output logic [ADDR_WIDTH:0]            pending_count
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   pending_q;
    logic [NUM_REGS-1:0]   pending_d;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_d;

    logic wr_valid;
    logic rsv_valid;
    logic set_new;
    logic clr_new;

    // Index 0 is hard-wired: it is never written nor reserved, so it stays at its reset value.
    assign wr_valid  = ctrl_writeEnable && (ctrl_writeReg != '0);
    assign rsv_valid = ctrl_reserve && (ctrl_reserveReg != '0);

    always_comb begin
        regs_d    = regs_q;
        pending_d = pending_q;
        if (wr_valid) begin
            regs_d[ctrl_writeReg]    = data_writeReg;
            pending_d[ctrl_writeReg] = 1'b0;
        end
        // Reserve is applied last so a new producer supersedes a completing one.
        if (rsv_valid) begin
            pending_d[ctrl_reserveReg] = 1'b1;
        end
    end

    // Count tracks popcount(pending) incrementally from the bits that actually flip.
    always_comb begin
        set_new = rsv_valid && !pending_q[ctrl_reserveReg];
        clr_new = wr_valid && pending_q[ctrl_writeReg]
                  && !(rsv_valid && (ctrl_reserveReg == ctrl_writeReg));
        count_d = count_q + {{ADDR_WIDTH{1'b0}}, set_new} - {{ADDR_WIDTH{1'b0}}, clr_new};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            regs_q    <= regs_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    assign pending_count = count_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_READ; gi++) begin : g_rd
            logic [ADDR_WIDTH-1:0] ridx;
            logic [DATA_WIDTH-1:0] rdata;
            logic                  rbusy;

            assign ridx = ctrl_readReg[gi*ADDR_WIDTH +: ADDR_WIDTH];

            always_comb begin
                rdata = regs_q[ridx];
                rbusy = pending_q[ridx];
`ifdef REGFILE_MP_BYPASS_EN
                // Forwarding is suppressed during reset so outputs stay at zero.
                if (reset && wr_valid && (ctrl_writeReg == ridx)) begin
                    rdata = data_writeReg;
                    rbusy = rsv_valid && (ctrl_reserveReg == ridx);
                end
`endif
            end

            assign data_readReg[gi*DATA_WIDTH +: DATA_WIDTH] = rdata;
            assign read_busy[gi] = rbusy;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (DATA_WIDTH=32, ADDR_WIDTH=5, NUM_READ=2).
// Expectations track REGFILE_MP_BYPASS_EN so the same bench covers both builds.
module tb_regfile_mp;

`ifdef REGFILE_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [9:0]  ctrl_readReg;
    logic [63:0] data_readReg;
    logic [1:0]  read_busy;
    logic        ctrl_reserve;
    logic [4:0]  ctrl_reserveReg;
    logic [5:0]  pending_count;

    logic [4:0]  rd0;
    logic [4:0]  rd1;
    logic [31:0] exp_d;
    logic [1:0]  exp_b;

    int vectors;
    int miscompares;

    assign ctrl_readReg = {rd1, rd0};

    regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) dut (
        .clock            (clock),
        .reset            (reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readReg     (ctrl_readReg),
        .data_readReg     (data_readReg),
        .read_busy        (read_busy),
        .ctrl_reserve     (ctrl_reserve),
        .ctrl_reserveReg  (ctrl_reserveReg),
        .pending_count    (pending_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Advance one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = '0;
        data_writeReg    = '0;
        ctrl_reserve     = 1'b0;
        ctrl_reserveReg  = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        rd0 = '0;
        rd1 = '0;
        step();
        step();
        for (int i = 0; i < 32; i++) begin
            rd0 = 5'(i);
            rd1 = 5'(31 - i);
            #1;
            vectors++;
            if (data_readReg !== 64'h0 || read_busy !== 2'b00 || pending_count !== 6'd0) begin
                miscompares++;
                $display("FAIL reset_state idx=%0d: data=%h busy=%b count=%0d, required data=0 busy=00 count=0",
                         i, data_readReg, read_busy, pending_count);
            end
        end
        reset = 1'b1;
        step();
        $display("test_reset: done");
    endtask

    task automatic test_write_read();
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd5;
        data_writeReg    = 32'hDEADBEEF;
        step();
        idle_inputs();
        rd0 = 5'd5;
        rd1 = 5'd5;
        #1;
        vectors++;
        if (data_readReg !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
            miscompares++;
            $display("FAIL write_r5: data=%h, required %h", data_readReg, {32'hDEADBEEF, 32'hDEADBEEF});
        end
        $display("write r5=DEADBEEF -> ports read %h", data_readReg);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'h1234;
        rd0 = 5'd0;
        rd1 = 5'd0;
        step();
        idle_inputs();
        #1;
        vectors++;
        if (data_readReg !== 64'h0 || read_busy !== 2'b00) begin
            miscompares++;
            $display("FAIL write_r0_ignored: data=%h busy=%b, required data=0 busy=00", data_readReg, read_busy);
        end
        $display("write r0=1234 -> r0 reads %h", data_readReg[31:0]);
    endtask

    task automatic test_reserve();
        ctrl_reserve    = 1'b1;
        ctrl_reserveReg = 5'd7;
        step();
        idle_inputs();
        rd0 = 5'd7;
        rd1 = 5'd7;
        #1;
        vectors++;
        if (read_busy !== 2'b11 || pending_count !== 6'd1) begin
            miscompares++;
            $display("FAIL reserve_r7: busy=%b count=%0d, required busy=11 count=1", read_busy, pending_count);
        end
        step();
        step();
        step();
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd7;
        data_writeReg    = 32'hA5A5A5A5;
        step();
        idle_inputs();
        #1;
        vectors++;
        if (read_busy !== 2'b00 || pending_count !== 6'd0 || data_readReg[31:0] !== 32'hA5A5A5A5) begin
            miscompares++;
            $display("FAIL complete_r7: busy=%b count=%0d data=%h, required busy=00 count=0 data=a5a5a5a5",
                     read_busy, pending_count, data_readReg[31:0]);
        end
        $display("reserve r7, write A5A5A5A5 -> busy=%b count=%0d", read_busy, pending_count);
    endtask

    task automatic test_same_edge();
        ctrl_reserve    = 1'b1;
        ctrl_reserveReg = 5'd9;
        step();
        // Write and reserve r9 together while r9 is already pending.
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd9;
        data_writeReg    = 32'h55;
        step();
        idle_inputs();
        rd0 = 5'd9;
        rd1 = 5'd9;
        #1;
        vectors++;
        if (data_readReg[31:0] !== 32'h55 || read_busy !== 2'b11 || pending_count !== 6'd1) begin
            miscompares++;
            $display("FAIL same_idx_wr_rsv: data=%h busy=%b count=%0d, required data=55 busy=11 count=1",
                     data_readReg[31:0], read_busy, pending_count);
        end
        ctrl_reserve    = 1'b1;
        ctrl_reserveReg = 5'd3;
        step();
        ctrl_reserveReg  = 5'd4;
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd3;
        data_writeReg    = 32'h33;
        step();
        idle_inputs();
        rd0 = 5'd3;
        rd1 = 5'd4;
        #1;
        vectors++;
        if (read_busy !== 2'b10 || pending_count !== 6'd2 || data_readReg[31:0] !== 32'h33) begin
            miscompares++;
            $display("FAIL diff_idx_wr_rsv: busy=%b count=%0d data=%h, required busy=10 count=2 data=33",
                     read_busy, pending_count, data_readReg[31:0]);
        end
        // Re-reserving a pending register and reserving r0 both leave the count alone.
        ctrl_reserve    = 1'b1;
        ctrl_reserveReg = 5'd4;
        step();
        ctrl_reserveReg = 5'd0;
        step();
        idle_inputs();
        rd0 = 5'd0;
        #1;
        vectors++;
        if (read_busy !== 2'b10 || pending_count !== 6'd2) begin
            miscompares++;
            $display("FAIL rereserve_r0: busy=%b count=%0d, required busy=10 count=2", read_busy, pending_count);
        end
        $display("same-edge cases -> count=%0d", pending_count);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            ctrl_writeEnable = 1'b1;
            ctrl_writeReg    = 5'(20 + i);
            data_writeReg    = 32'h100 + 32'(i);
            step();
        end
        idle_inputs();
        for (int i = 0; i < 4; i += 2) begin
            rd0 = 5'(20 + i);
            rd1 = 5'(21 + i);
            #1;
            vectors++;
            if (data_readReg !== {32'h101 + 32'(i), 32'h100 + 32'(i)} || read_busy !== 2'b00) begin
                miscompares++;
                $display("FAIL back_to_back r%0d/r%0d: data=%h busy=%b, required %h busy=00",
                         20 + i, 21 + i, data_readReg, read_busy, {32'h101 + 32'(i), 32'h100 + 32'(i)});
            end
        end
        $display("back-to-back writes r20..r23 checked");
    endtask

    task automatic test_async_reset();
        ctrl_reserve = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            ctrl_reserveReg = 5'(i);
            step();
        end
        idle_inputs();
        rd0 = 5'd5;
        rd1 = 5'd1;
        #1;
        vectors++;
        if (pending_count !== 6'd5 || data_readReg[31:0] !== 32'hDEADBEEF || read_busy !== 2'b10) begin
            miscompares++;
            $display("FAIL pre_reset: count=%0d data=%h busy=%b, required count=5 data=deadbeef busy=10",
                     pending_count, data_readReg[31:0], read_busy);
        end
        #1;
        reset = 1'b0;
        #1;
        vectors++;
        if (data_readReg !== 64'h0 || read_busy !== 2'b00 || pending_count !== 6'd0) begin
            miscompares++;
            $display("FAIL async_reset: data=%h busy=%b count=%0d, required all 0",
                     data_readReg, read_busy, pending_count);
        end
        // A write presented while reset is held must not land.
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd5;
        data_writeReg    = 32'hFFFF0000;
        step();
        idle_inputs();
        reset = 1'b1;
        step();
        for (int i = 0; i < 32; i += 2) begin
            rd0 = 5'(i);
            rd1 = 5'(i + 1);
            #1;
            vectors++;
            if (data_readReg !== 64'h0 || read_busy !== 2'b00 || pending_count !== 6'd0) begin
                miscompares++;
                $display("FAIL post_reset r%0d/r%0d: data=%h busy=%b count=%0d, required all 0",
                         i, i + 1, data_readReg, read_busy, pending_count);
            end
        end
        $display("async reset mid-operation -> cleared");
    endtask

    task automatic test_bypass();
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd12;
        data_writeReg    = 32'h11;
        step();
        data_writeReg = 32'hCAFE;
        rd0 = 5'd0;
        rd1 = 5'd12;
        #1;
        exp_d = BYP ? 32'hCAFE : 32'h11;
        vectors++;
        if (data_readReg[63:32] !== exp_d || data_readReg[31:0] !== 32'h0) begin
            miscompares++;
            $display("FAIL bypass_data: port1=%h port0=%h, required port1=%h port0=0",
                     data_readReg[63:32], data_readReg[31:0], exp_d);
        end
        ctrl_reserve    = 1'b1;
        ctrl_reserveReg = 5'd12;
        #1;
        exp_b = BYP ? 2'b10 : 2'b00;
        vectors++;
        if (read_busy !== exp_b) begin
            miscompares++;
            $display("FAIL bypass_busy_rsv: busy=%b, required %b", read_busy, exp_b);
        end
        step();
        idle_inputs();
        #1;
        vectors++;
        if (data_readReg[63:32] !== 32'hCAFE || read_busy !== 2'b10 || pending_count !== 6'd1) begin
            miscompares++;
            $display("FAIL after_edge_r12: data=%h busy=%b count=%0d, required data=cafe busy=10 count=1",
                     data_readReg[63:32], read_busy, pending_count);
        end
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd12;
        data_writeReg    = 32'hBEEF;
        #1;
        exp_d = BYP ? 32'hBEEF : 32'hCAFE;
        exp_b = BYP ? 2'b00 : 2'b10;
        vectors++;
        if (data_readReg[63:32] !== exp_d || read_busy !== exp_b) begin
            miscompares++;
            $display("FAIL bypass_clear: data=%h busy=%b, required data=%h busy=%b",
                     data_readReg[63:32], read_busy, exp_d, exp_b);
        end
        step();
        idle_inputs();
        #1;
        vectors++;
        if (data_readReg[63:32] !== 32'hBEEF || read_busy !== 2'b00 || pending_count !== 6'd0) begin
            miscompares++;
            $display("FAIL final_r12: data=%h busy=%b count=%0d, required data=beef busy=00 count=0",
                     data_readReg[63:32], read_busy, pending_count);
        end
        $display("bypass (enabled=%0d) r12 checked", BYP);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        rd0         = '0;
        rd1         = '0;
        idle_inputs();
        test_reset();
        test_write_read();
        test_reserve();
        test_same_edge();
        test_back_to_back();
        test_async_reset();
        test_bypass();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
